ibis_scanline_buffer: RTL and testbench
=======================================

Name: ibis_scanline_buffer

Overview:
Double-buffered scanline store between a pixel source and the three ibis_tmds encoders. It prefetches line y+1 from an upstream valid/ready stream while line y is displayed. Active pixels are read back indexed by ord_x from ibis_vga_timing. It emits 8-bit R/G/B, data_enable and {vsync,hsync}, all aligned with each other, to the TMDS encoders.

Parameters:
H_ACTIVE, 640, active pixels per line; also the RAM depth per bank.
V_ACTIVE, 480, active lines per frame.
V_TOTAL, 525, total lines per frame; ord_y range is 0..V_TOTAL-1.
X_W, 10, width of ord_x, ord_y and req_y.

Ports:
aclk  in  1  single clock; all logic on rising edge
aresetn  in  1  asynchronous, active-low reset
enable  in  1  clock enable; low freezes all state and forces s_tready=0
vsync, hsync, vblank, hblank  in  1 each  from ibis_vga_timing
ord_x, ord_y  in  X_W each  from ibis_vga_timing; ord_y holds y through that line's hblank
req_valid  out  1  line request pending
req_ready  in  1  upstream accepts the request
req_y  out  X_W  line number requested
s_tdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}
s_tvalid  in  1  pixel beat valid
s_tready  out  1  buffer accepts the beat
s_tlast  in  1  last beat of the line (may come early)
out_red, out_grn, out_blu  out  8 each  pixel to the encoders
out_data_enable  out  1  active-video qualifier
out_control  out  2  {vsync,hsync}, delayed
underrun  out  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0. Fill FSM = IDLE, disp_valid=0, disp_bank=0, wr_ptr=0. RAM contents undefined.
- Storage: one simple dual-port RAM of depth 2*H_ACTIVE; the bank bit is the address MSB. The fill bank is always ~disp_bank.
- line_end event: hblank rises (hblank=1, hblank_d=0) with enable=1. Let y=ord_y, n=(y+1) mod V_TOTAL, r=(y+2) mod V_TOTAL.
- At line_end with n<V_ACTIVE:
  - If fill state is DONE, or the final beat is accepted this same cycle: toggle disp_bank, set disp_count=wr_count, set disp_valid=1.
  - Otherwise: underrun pulse, disp_valid=0, current fill aborted.
- At line_end with r<V_ACTIVE: wr_ptr=0, FSM -> REQ with req_y=r. Otherwise FSM -> IDLE.
- Fill FSM transitions:
  - IDLE -> REQ only via line_end.
  - REQ: req_valid=1, req_y stable until req_ready. REQ -> FILL on req_ready.
  - FILL: s_tready=1. Each accepted beat writes to addr {~disp_bank, wr_ptr}, then wr_ptr++.
  - FILL -> DONE when the beat at wr_ptr==H_ACTIVE-1 is accepted, or on an accepted s_tlast; wr_count = wr_ptr+1. s_tlast is ignored at the final beat.
  - DONE: s_tready=0.
- A new request issued while in REQ replaces req_y. Upstream discards its unsent beats when a new request appears.
- Read path:
  - Address {disp_bank, ord_x} when vblank|hblank is 0.
  - RAM read is registered, then the output register: total latency 2 cycles.
  - Pixel output = 0 when !disp_valid, or ord_x>=disp_count, or outside active video.
  - data_enable and control pass through the same 2-stage delay.
- Reset mid-line: immediate return to reset values. The first line after reset is black (underrun is not pulsed until a fill has been requested).

Optional Feature:
IBIS_SCANLINE_UNDERRUN_CNT_EN:
- Defined: adds output underrun_count[15:0]. It increments on each underrun pulse, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: the port and counter are absent; the underrun pulse is still present.

Decomposition:
- Shared package ibis_video_pkg:
  - H_ACTIVE, V_ACTIVE, V_TOTAL defaults.
  - rgb888_t typedef.
  - Fill-state encoding: IDLE=0, REQ=1, FILL=2, DONE=3.
- Sub-module ibis_line_ram: simple dual-port RAM, 1 write port, 1 registered read port, depth 2*H_ACTIVE, 24-bit. Instantiated once.

Test Plan:
- Reset, then run through vblank; at the line_end with ord_y=523: req_valid=1, req_y=0. After req_ready, s_tready=1.
- Stream 640 beats with data=x; at line_end with ord_y=524 a swap occurs. On line 0, pixel x appears 2 cycles after ord_x=x, with out_data_enable aligned.
- Hold s_tvalid low for all of line 5's fill: at the next line_end, underrun=1 for one cycle and line 5 outputs all zeros. The line 6 request is then issued, and line 6 displays correctly.
- s_tlast on beat 99 (wr_ptr=99): FSM goes to DONE, disp_count=100. Pixels x>=100 output 0.
- Final beat accepted in the same cycle as line_end: swap proceeds, no underrun.
- Deassert aresetn mid-FILL: all outputs and req_valid/s_tready go to 0 immediately. With the macro defined, underrun_count returns to 0.

Source files
------------

// File: rtl/ibis_video_pkg.sv
// ---------------------------------------------------------------------------
// ibis_video_pkg
// Shared video definitions for the ibis display pipeline:
//   - default raster geometry (active pixels, active lines, total lines)
//   - rgb888_t pixel type
//   - fill-state encoding used by the scanline buffer
//   - wrap_add(): line-number increment modulo the frame height
// ---------------------------------------------------------------------------
package ibis_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_X_W      = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_REQ  = 2'd1,
        FILL_FILL = 2'd2,
        FILL_DONE = 2'd3
    } fill_state_e;

    // (y + inc) mod total, valid for y < total and inc <= total.
    function automatic logic [31:0] wrap_add(input logic [31:0] y,
                                             input logic [31:0] inc,
                                             input logic [31:0] total);
        logic [31:0] sum;
        sum = y + inc;
        return (sum >= total) ? sum - total : sum;
    endfunction

endpackage

// File: rtl/ibis_line_ram.sv
// ---------------------------------------------------------------------------
// ibis_line_ram
// Simple dual-port line RAM holding two banks of DEPTH words each.
// Address MSB selects the bank, the low AW bits index the pixel.
// Ports:
//   clk_i                      write and read clock
//   wr_en_i/wr_addr_i/wr_data_i  write port
//   rd_en_i/rd_addr_i          read request; rd_data_o valid one cycle later
//   rd_data_o                  registered read data (holds when rd_en_i=0)
// ---------------------------------------------------------------------------
module ibis_line_ram
    import ibis_video_pkg::*;
#(
    parameter int DEPTH = DEF_H_ACTIVE,
    parameter int AW    = DEF_X_W,
    parameter int DW    = 24
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW:0]   wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW:0]   rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2][DEPTH];

    // NOTE: the array and its read register have no reset so the tools can
    // map them onto block RAM; consumers gate the data until it is written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i[AW]][wr_addr_i[AW-1:0]] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i[AW]][rd_addr_i[AW-1:0]];
        end
    end

endmodule

// File: rtl/ibis_scanline_buffer.sv
// ---------------------------------------------------------------------------
// ibis_scanline_buffer
// Double-buffered scanline store between a pixel source and the TMDS
// encoders. Line y+1 is prefetched from an upstream valid/ready stream into
// the fill bank while line y is read out of the display bank by ord_x.
//
// Ports:
//   aclk, aresetn           clock, asynchronous active-low reset
//   enable                  clock enable; low freezes state, s_tready=0
//   vsync/hsync/vblank/hblank, ord_x, ord_y   raster timing inputs
//   req_valid/req_ready/req_y                 line request handshake
//   s_tdata/s_tvalid/s_tready/s_tlast         pixel stream {R,G,B}
//   out_red/out_grn/out_blu, out_data_enable,
//   out_control {vsync,hsync}                 2-cycle aligned outputs
//   underrun                                  one-cycle pulse
//
// Build option: define IBIS_SCANLINE_UNDERRUN_CNT_EN to add the saturating
// 16-bit underrun_count output.
// ---------------------------------------------------------------------------
module ibis_scanline_buffer
    import ibis_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int X_W      = DEF_X_W
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic           enable,
    input  logic           vsync,
    input  logic           hsync,
    input  logic           vblank,
    input  logic           hblank,
    input  logic [X_W-1:0] ord_x,
    input  logic [X_W-1:0] ord_y,
    output logic           req_valid,
    input  logic           req_ready,
    output logic [X_W-1:0] req_y,
    input  logic [23:0]    s_tdata,
    input  logic           s_tvalid,
    output logic           s_tready,
    input  logic           s_tlast,
    output logic [7:0]     out_red,
    output logic [7:0]     out_grn,
    output logic [7:0]     out_blu,
    output logic           out_data_enable,
    output logic [1:0]     out_control,
    output logic           underrun
`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
    ,
    output logic [15:0]    underrun_count
`endif
);

    // Fill side state
    fill_state_e    fill_q;
    logic [X_W-1:0] wr_ptr_q;
    logic [X_W-1:0] wr_count_q;
    logic [X_W-1:0] req_y_q;
    logic           disp_bank_q;
    logic [X_W-1:0] disp_count_q;
    logic           disp_valid_q;
    logic           hblank_q;
    logic           underrun_q;

    // Read pipeline state
    logic           de_q1;
    logic [1:0]     ctl_q1;
    logic           pix_ok_q1;
    rgb888_t        rd_pix;
    rgb888_t        out_pix_q;
    logic           out_de_q;
    logic [1:0]     out_ctl_q;

    logic [31:0]    n_line;
    logic [31:0]    r_line;
    logic           line_end;
    logic           n_vis;
    logic           r_vis;
    logic           beat_acc;
    logic           beat_final;
    logic           active;
    logic           pix_ok;

    assign line_end   = enable && hblank && !hblank_q;
    assign n_line     = wrap_add(32'(ord_y), 32'd1, 32'(V_TOTAL));
    assign r_line     = wrap_add(32'(ord_y), 32'd2, 32'(V_TOTAL));
    assign n_vis      = n_line < 32'(V_ACTIVE);
    assign r_vis      = r_line < 32'(V_ACTIVE);

    assign beat_acc   = enable && (fill_q == FILL_FILL) && s_tvalid;
    // A short line ends on s_tlast; at the last RAM slot s_tlast is moot.
    assign beat_final = beat_acc && ((wr_ptr_q == X_W'(H_ACTIVE - 1)) || s_tlast);

    assign active     = !(vblank || hblank);
    assign pix_ok     = active && disp_valid_q && (ord_x < disp_count_q);

    ibis_line_ram #(
        .DEPTH (H_ACTIVE),
        .AW    (X_W),
        .DW    (24)
    ) u_ram (
        .clk_i     (aclk),
        .wr_en_i   (beat_acc),
        .wr_addr_i ({~disp_bank_q, wr_ptr_q}),
        .wr_data_i (s_tdata),
        .rd_en_i   (enable && active),
        .rd_addr_i ({disp_bank_q, ord_x}),
        .rd_data_o (rd_pix)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fill_q       <= FILL_IDLE;
            wr_ptr_q     <= '0;
            wr_count_q   <= '0;
            req_y_q      <= '0;
            disp_bank_q  <= 1'b0;
            disp_count_q <= '0;
            disp_valid_q <= 1'b0;
            hblank_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // The pulse drops even while frozen so it never stretches.
            underrun_q <= 1'b0;
            if (enable) begin
                hblank_q <= hblank;
                case (fill_q)
                    FILL_REQ: begin
                        if (req_ready) fill_q <= FILL_FILL;
                    end
                    FILL_FILL: begin
                        if (beat_acc) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            if (beat_final) begin
                                fill_q     <= FILL_DONE;
                                wr_count_q <= wr_ptr_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase

                // Line boundary: swap banks and launch the next prefetch.
                // Assignments here deliberately override the fill progress.
                if (line_end) begin
                    if (n_vis) begin
                        if (fill_q == FILL_DONE || beat_final) begin
                            disp_bank_q  <= ~disp_bank_q;
                            disp_count_q <= beat_final ? wr_ptr_q + 1'b1 : wr_count_q;
                            disp_valid_q <= 1'b1;
                        end else begin
                            disp_valid_q <= 1'b0;
                            // IDLE here only follows reset: no fill was owed.
                            underrun_q   <= (fill_q != FILL_IDLE);
                        end
                    end
                    if (r_vis) begin
                        wr_ptr_q <= '0;
                        req_y_q  <= X_W'(r_line);
                        fill_q   <= FILL_REQ;
                    end else begin
                        fill_q   <= FILL_IDLE;
                    end
                end
            end
        end
    end

    // Two-stage read pipeline: RAM register, then output register. The
    // qualifiers travel alongside so everything leaves aligned.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            de_q1     <= 1'b0;
            ctl_q1    <= '0;
            pix_ok_q1 <= 1'b0;
            out_pix_q <= '0;
            out_de_q  <= 1'b0;
            out_ctl_q <= '0;
        end else if (enable) begin
            de_q1     <= active;
            ctl_q1    <= {vsync, hsync};
            pix_ok_q1 <= pix_ok;
            out_pix_q <= pix_ok_q1 ? rd_pix : '0;
            out_de_q  <= de_q1;
            out_ctl_q <= ctl_q1;
        end
    end

    assign req_valid       = (fill_q == FILL_REQ);
    assign req_y           = req_y_q;
    assign s_tready        = enable && (fill_q == FILL_FILL);
    assign out_red         = out_pix_q.r;
    assign out_grn         = out_pix_q.g;
    assign out_blu         = out_pix_q.b;
    assign out_data_enable = out_de_q;
    assign out_control     = out_ctl_q;
    assign underrun        = underrun_q;

`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            underrun_cnt_q <= '0;
        end else if (underrun_q && underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_count = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_ibis_scanline_buffer.sv
// ---------------------------------------------------------------------------
// tb_ibis_scanline_buffer
// Drives a compressed raster (640 active + 20 blank cycles per line) through
// a table of lines, with a bench-side upstream that answers line requests.
// Special lines: 3 delivers its last beat exactly on the line_end cycle,
// 5 never delivers (stall), 7 ends early with s_tlast on beat 99.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ibis_scanline_buffer;
    import ibis_video_pkg::*;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int H_TOT   = 660;
    localparam int X_W     = 10;
    localparam int EDGE_Y  = 3;
    localparam int STALL_Y = 5;
    localparam int SHORT_Y = 7;
    localparam int SHORT_N = 100;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic           enable = 1'b1;
    logic           vsync = 1'b0, hsync = 1'b0, vblank = 1'b1, hblank = 1'b0;
    logic [X_W-1:0] ord_x = '0, ord_y = '0;
    logic           req_valid, req_ready = 1'b0;
    logic [X_W-1:0] req_y;
    logic [23:0]    s_tdata = '0;
    logic           s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [7:0]     out_red, out_grn, out_blu;
    logic           out_data_enable;
    logic [1:0]     out_control;
    logic           underrun;
`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
    logic [15:0]    underrun_count;
`endif

    always #5 aclk = ~aclk;

    ibis_scanline_buffer dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable          (enable),
        .vsync           (vsync),
        .hsync           (hsync),
        .vblank          (vblank),
        .hblank          (hblank),
        .ord_x           (ord_x),
        .ord_y           (ord_y),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_y           (req_y),
        .s_tdata         (s_tdata),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .s_tlast         (s_tlast),
        .out_red         (out_red),
        .out_grn         (out_grn),
        .out_blu         (out_blu),
        .out_data_enable (out_data_enable),
        .out_control     (out_control),
        .underrun        (underrun)
`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
        ,
        .underrun_count  (underrun_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pixel content for line y, column x.
    function automatic logic [23:0] pix(input int y, input int x);
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(x);
        yv = 10'(y);
        return {xv[7:0], {yv[5:0], xv[9:8]}, xv[7:0] ^ 8'h5A};
    endfunction

    // Per-line record: timing input plus expected behaviour on that line.
    typedef struct {
        int y;          // ord_y for the line
        int cnt;        // pixels expected non-black on this line's display
        bit exp_req;    // req_valid right after this line's line_end
        int exp_req_y;  // requested line number
        bit exp_ur;     // underrun pulse after this line's line_end
        bit exp_tready; // s_tready at x=400 of this line
    } line_vec_t;

    line_vec_t vecs[12];

    // Expected-output history: entry [2] is what must appear this cycle.
    logic [23:0] q_pix[3];
    logic        q_de[3];
    logic [1:0]  q_ctl[3];
    int          q_x[3];

    task automatic run_line(input line_vec_t v);
        logic de;
        logic [23:0] p;
        for (int x = 0; x < H_TOT; x++) begin
            @(posedge aclk); #1;
            ord_x  = 10'(x);
            ord_y  = 10'(v.y);
            hblank = (x >= H_ACT);
            vblank = (v.y >= V_ACT);
            hsync  = (x >= 645 && x < 655);
            vsync  = (v.y == 490 || v.y == 491);
            de     = !(hblank || vblank);
            p      = (de && x < v.cnt) ? pix(v.y, x) : 24'h0;
            for (int k = 2; k > 0; k--) begin
                q_pix[k] = q_pix[k-1];
                q_de[k]  = q_de[k-1];
                q_ctl[k] = q_ctl[k-1];
                q_x[k]   = q_x[k-1];
            end
            q_pix[0] = p;
            q_de[0]  = de;
            q_ctl[0] = {vsync, hsync};
            q_x[0]   = x;
            @(negedge aclk);
            check($sformatf("pix y%0d x%0d", v.y, q_x[2]), 32'({out_red, out_grn, out_blu}), 32'(q_pix[2]));
            check($sformatf("de y%0d x%0d", v.y, q_x[2]), 32'(out_data_enable), 32'(q_de[2]));
            check($sformatf("ctl y%0d x%0d", v.y, q_x[2]), 32'(out_control), 32'(q_ctl[2]));
            if (x == 400) check($sformatf("s_tready y%0d", v.y), 32'(s_tready), 32'(v.exp_tready));
            if (x == H_ACT + 1) begin
                check($sformatf("req_valid y%0d", v.y), 32'(req_valid), 32'(v.exp_req));
                if (v.exp_req) check($sformatf("req_y y%0d", v.y), 32'(req_y), 32'(v.exp_req_y));
                check($sformatf("underrun y%0d", v.y), 32'(underrun), 32'(v.exp_ur));
            end
            if (x == H_ACT + 2 && v.exp_ur) check($sformatf("underrun pulse end y%0d", v.y), 32'(underrun), 32'd0);
        end
    endtask

    // Upstream source: accepts every request, streams the requested line,
    // drops an unfinished line as soon as a new request appears.
    initial begin : upstream
        bit         have;
        bit         acc_b;
        bit         acc_r;
        int         line;
        int         beat;
        logic [9:0] cap_y;
        have = 1'b0;
        line = 0;
        beat = 0;
        forever begin
            @(negedge aclk);
            acc_b = s_tvalid && s_tready;
            acc_r = req_valid && req_ready;
            cap_y = req_y;
            @(posedge aclk); #2;
            if (!aresetn) have = 1'b0;
            if (acc_r) begin
                have = 1'b1;
                line = int'(cap_y);
                beat = 0;
            end
            if (acc_b) begin
                beat++;
                if (beat == ((line == SHORT_Y) ? SHORT_N : H_ACT)) have = 1'b0;
            end
            if (req_valid && have) have = 1'b0;
            req_ready = req_valid;
            s_tvalid  = have && (line != STALL_Y) &&
                        !(line == EDGE_Y && beat == H_ACT - 1 && int'(ord_x) != H_ACT);
            s_tdata   = pix(line, beat);
            s_tlast   = have && (line == SHORT_Y) && (beat == SHORT_N - 1);
        end
    end

    initial begin
        //            y    cnt  req y   ur tready
        vecs[0]  = '{522, 0,   0,  0,  0, 0};
        vecs[1]  = '{523, 0,   1,  0,  0, 0};
        vecs[2]  = '{524, 0,   1,  1,  0, 1};
        vecs[3]  = '{0,   640, 1,  2,  0, 1};
        vecs[4]  = '{1,   640, 1,  3,  0, 1};
        vecs[5]  = '{2,   640, 1,  4,  0, 1};
        vecs[6]  = '{3,   640, 1,  5,  0, 1};
        vecs[7]  = '{4,   640, 1,  6,  1, 1};
        vecs[8]  = '{5,   0,   1,  7,  0, 1};
        vecs[9]  = '{6,   640, 1,  8,  0, 0};
        vecs[10] = '{7,   100, 1,  9,  0, 1};
        vecs[11] = '{8,   640, 1,  10, 0, 1};
        for (int k = 0; k < 3; k++) begin
            q_pix[k] = '0;
            q_de[k]  = 1'b0;
            q_ctl[k] = '0;
            q_x[k]   = 0;
        end
        ord_y = 10'd522;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset pix", 32'({out_red, out_grn, out_blu}), 32'd0);
        check("reset de", 32'(out_data_enable), 32'd0);
        check("reset ctl", 32'(out_control), 32'd0);
        check("reset underrun", 32'(underrun), 32'd0);
        check("reset req_valid", 32'(req_valid), 32'd0);
        check("reset req_y", 32'(req_y), 32'd0);
        check("reset s_tready", 32'(s_tready), 32'd0);
        aresetn = 1'b1;

        for (int i = 0; i < 12; i++) run_line(vecs[i]);

`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
        check("underrun_count after stall", 32'(underrun_count), 32'd1);
`endif

        // Asynchronous reset while line 10 is being filled.
        @(posedge aclk); #3;
        check("s_tready before mid reset", 32'(s_tready), 32'd1);
        aresetn = 1'b0;
        #1;
        check("mid reset pix", 32'({out_red, out_grn, out_blu}), 32'd0);
        check("mid reset de", 32'(out_data_enable), 32'd0);
        check("mid reset ctl", 32'(out_control), 32'd0);
        check("mid reset req_valid", 32'(req_valid), 32'd0);
        check("mid reset req_y", 32'(req_y), 32'd0);
        check("mid reset s_tready", 32'(s_tready), 32'd0);
        check("mid reset underrun", 32'(underrun), 32'd0);
`ifdef IBIS_SCANLINE_UNDERRUN_CNT_EN
        check("mid reset underrun_count", 32'(underrun_count), 32'd0);
`endif
        repeat (2) @(posedge aclk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
